// File: rtl/sym_decoder_if.sv
// Symbol-in / bit-and-word-out bundle between the link receiver and sym_decoder.
// No latency of its own; wires only.
// No backpressure: the slave consumes one symbol whenever sym_valid is high.
// SYM_DEC_ERR_CNT_EN adds the err_cnt signal and its width parameter.
interface sym_decoder_if #(
  parameter int DATA_W = 8
`ifdef SYM_DEC_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
);
  logic [1:0]        sym_in;
  logic              sym_valid;
  logic              resync;
  logic              bit_out;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              err;
`ifdef SYM_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  modport master (
    output sym_in, sym_valid, resync,
    input  bit_out, bit_valid, data_out, data_valid, err
`ifdef SYM_DEC_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  sym_in, sym_valid, resync,
    output bit_out, bit_valid, data_out, data_valid, err
`ifdef SYM_DEC_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/sym_decoder.sv
// 4-state Mealy line-code decoder: 2-bit symbols -> recovered bits -> DATA_W-bit words.
// Latency 1 cycle from symbol to bit_out/bit_valid/err; data_valid rides with the last bit.
// No backpressure: one symbol per cycle when sym_valid; gaps hold state. SYM_DEC_ERR_CNT_EN adds err_cnt.
module sym_decoder #(
  parameter int DATA_W = 8
`ifdef SYM_DEC_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         rst,
  sym_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t            state;
  state_t            state_d;
  state_t            dec_nxt;
  logic              dec_bit;
  logic              dec_ok;
  logic [CNT_W-1:0]  cnt;
  // Only DATA_W-1 bits of history are needed; the newest bit comes from the decoder.
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] word;

  assign word = {shreg, dec_bit};

  // Decode table lookup and next-state selection (resync, then symbol legality).
  always_comb begin
    dec_bit = 1'b0;
    dec_ok  = 1'b0;
    dec_nxt = S0;
    case (state)
      S0: case (bus.sym_in)
            2'd0: begin dec_ok = 1'b1; dec_bit = 1'b0; dec_nxt = S0; end
            2'd1: begin dec_ok = 1'b1; dec_bit = 1'b1; dec_nxt = S1; end
            default: ;
          endcase
      S1: case (bus.sym_in)
            2'd0: begin dec_ok = 1'b1; dec_bit = 1'b0; dec_nxt = S2; end
            2'd2: begin dec_ok = 1'b1; dec_bit = 1'b1; dec_nxt = S3; end
            default: ;
          endcase
      S2: case (bus.sym_in)
            2'd1: begin dec_ok = 1'b1; dec_bit = 1'b0; dec_nxt = S2; end
            2'd0: begin dec_ok = 1'b1; dec_bit = 1'b1; dec_nxt = S3; end
            default: ;
          endcase
      S3: case (bus.sym_in)
            2'd1: begin dec_ok = 1'b1; dec_bit = 1'b0; dec_nxt = S1; end
            2'd0: begin dec_ok = 1'b1; dec_bit = 1'b1; dec_nxt = S0; end
            default: ;
          endcase
      default: ;
    endcase

    state_d = state;
    if (bus.resync) begin
      state_d = S0;
    end else if (bus.sym_valid) begin
      // An illegal symbol drops back to S0 so the encoder can be reacquired.
      state_d = dec_ok ? dec_nxt : S0;
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
    end else begin
      state <= state_d;
    end
  end

  // Bit output, word assembly and the single-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bit_out    <= 1'b0;
      bus.bit_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.err        <= 1'b0;
      shreg          <= '0;
      cnt            <= '0;
    end else begin
      bus.bit_valid  <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.err        <= 1'b0;
      if (bus.resync) begin
        // The symbol in a resync cycle is dropped; data_out is kept.
        shreg <= '0;
        cnt   <= '0;
      end else if (bus.sym_valid) begin
        if (dec_ok) begin
          bus.bit_out   <= dec_bit;
          bus.bit_valid <= 1'b1;
          shreg         <= word[DATA_W-2:0];
          if (cnt == CNT_W'(DATA_W - 1)) begin
            bus.data_out   <= word;
            bus.data_valid <= 1'b1;
            cnt            <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          bus.err <= 1'b1;
          shreg   <= '0;
          cnt     <= '0;
        end
      end
    end
  end

`ifdef SYM_DEC_ERR_CNT_EN
  // Saturating count of illegal symbols; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.err_cnt <= '0;
    end else if (bus.sym_valid && !bus.resync && !dec_ok && (bus.err_cnt != '1)) begin
      bus.err_cnt <= bus.err_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/sym_decoder.md
# sym_decoder

Serial symbol decoder for the 4-state, 1-bit-in / 2-bit-out Mealy line code used by the link FSM encoder. It tracks the encoder state and recovers each transmitted bit from the 2-bit symbol stream. It flags symbols that are illegal for the current state. It assembles recovered bits into DATA_W-bit words for the downstream datapath.

## Interface
- DATA_W, 8, width of an assembled word (2..32)
- ERR_CNT_W, 8, width of the error counter (present only with SYM_DEC_ERR_CNT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sym_in  in  2  encoded symbol
- sym_valid  in  1  sym_in is valid this cycle; one symbol is consumed per cycle when high
- resync  in  1  synchronous: force decoder state to S0 and discard the partial word
- bit_out  out  1  recovered bit
- bit_valid  out  1  one-cycle pulse; bit_out is valid
- data_out  out  DATA_W  last completed word, MSB-first; held until the next word completes
- data_valid  out  1  one-cycle pulse; data_out was updated
- err  out  1  one-cycle pulse; illegal symbol received
- err_cnt  out  ERR_CNT_W  saturating count of illegal symbols (macro only)

## Operation
- The decoder state is S0..S3 and mirrors the encoder. Reset state is S0.
- Decode rules, per state (symbol -> bit, next state):
  - S0: 0 -> 0, S0. 1 -> 1, S1.
  - S1: 0 -> 0, S2. 2 -> 1, S3.
  - S2: 1 -> 0, S2. 0 -> 1, S3.
  - S3: 1 -> 0, S1. 0 -> 1, S0.
- Any other (state, symbol) pair is illegal. In that case:
  - err pulses.
  - The state goes to S0.
  - The partial word and bit count are cleared.
  - bit_valid stays low.
  - err_cnt increments.
- When sym_valid is low, nothing changes and all pulse outputs are low.
- Word assembly: each valid bit is shifted in at the LSB of a shift register (shift left), so the first bit lands in data_out[DATA_W-1].
  - A bit counter runs 0..DATA_W-1.
  - On the DATA_W-th bit, data_out is loaded with the full word, data_valid pulses, and the counter wraps to 0.
- resync has priority over sym_valid. The symbol in that cycle is dropped with no bit, no err and no count change. The state goes to S0, and the shift register and bit counter clear. data_out and err_cnt are held.
- Reset values: state S0, bit counter 0, bit_out 0, bit_valid 0, data_out 0, data_valid 0, err 0, err_cnt 0.
- Reset mid-word drops the partial word. Decoding restarts from S0.

## Timing
- All outputs are registered.
- Symbol sampled at edge k -> bit_out/bit_valid/err are valid in the cycle after edge k. Latency is 1 cycle.
- data_valid is asserted in the same cycle as the bit_valid of the final bit of the word.
- Back-to-back symbols are accepted every cycle, so throughput is 1 bit/cycle.
- Gaps in sym_valid of any length are allowed. The state and partial word are retained across a gap.
- err and bit_valid are never high in the same cycle.

## Configuration
- SYM_DEC_ERR_CNT_EN defined:
  - The err_cnt port and counter exist.
  - The counter increments on each err pulse and saturates at 2^ERR_CNT_W-1.
  - Only rst clears it.
- SYM_DEC_ERR_CNT_EN undefined:
  - There is no err_cnt port and no counter logic.
  - The err pulse behaviour is unchanged.

## Test plan
- After reset, send symbols 1,0,0,0 on consecutive cycles -> bit_out 1,0,1,1 with bit_valid each cycle, err never set, final state S0.
- DATA_W=8, symbols 1,0,0,1,0,0,1,2 -> data_out=0xA5 with a data_valid pulse aligned to the 8th bit_valid, final state S3.
- From S0, send symbol 2 -> err pulse one cycle after, no bit_valid, state S0, err_cnt=1. Next send symbol 1 -> bit 1 decoded normally.
- Send 5 valid symbols of a word, then an illegal symbol, then 8 valid symbols -> only one data_valid, and it carries the 8 post-error bits.
- resync asserted together with sym_valid mid-word -> no bit_valid, no err, partial word discarded, next 8 bits form a clean word. Separately, rst pulled low mid-word -> all outputs 0 immediately.
- With the macro defined and ERR_CNT_W=8, send 256 illegal symbols -> err_cnt stays at 255. Gaps inserted in sym_valid -> no change in decoded results.
